// File: rtl/burst_sequencer.sv
// ============================================================================
// Module   : burst_sequencer
// Purpose  : Sequences a fixed number of pulse bursts with idle gaps, burst
//            completion handshake, timeout detection and abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_sequencer #(
   parameter int unsigned BURSTS  = 8,
   parameter int unsigned GAP     = 16,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       done_in,
   output logic       run,
   output logic       busy,
   output logic [7:0] burst_cnt,
   output logic       fin,
   output logic       err
);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_arm   = 3'd1;
   localparam logic [2:0] c_fire  = 3'd2;
   localparam logic [2:0] c_gap   = 3'd3;
   localparam logic [2:0] c_error = 3'd4;

   localparam logic [7:0] c_bursts     = 8'(BURSTS);
   localparam logic [7:0] c_gap_len    = 8'(GAP);
   localparam logic [7:0] c_timeout_m1 = 8'(TIMEOUT - 1);

   logic [2:0] state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [7:0] gap_q, gap_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       fin_q, fin_d;
   logic       run_q, run_d;
   logic       busy_q, busy_d;
   logic       w_done;
   logic [7:0] w_cnt_inc;

   // The gate may still show the previous burst's flag on the first FIRE cycle
   assign w_done    = done_in && (timer_q != 8'd0);
   assign w_cnt_inc = cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= c_idle;
         timer_q <= 8'd0;
         gap_q   <= 8'd0;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
         fin_q   <= 1'b0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fin_q   <= fin_d;
         run_q   <= run_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fin_d   = 1'b0;
      case (state_q)
         c_idle: begin
            if (start && !abort) begin
               state_d = c_arm;
               cnt_d   = 8'd0;
               err_d   = 1'b0;
            end
         end
         c_arm: begin
            if (abort) begin
               state_d = c_idle;
            end else begin
               state_d = c_fire;
               timer_d = 8'd0;
            end
         end
         c_fire: begin
            // Completion beats timeout when both land on the last FIRE cycle
            if (abort) begin
               state_d = c_idle;
            end else if (w_done) begin
               cnt_d = w_cnt_inc;
               if (w_cnt_inc == c_bursts) begin
                  state_d = c_idle;
                  fin_d   = 1'b1;
               end else if (c_gap_len == 8'd0) begin
                  state_d = c_arm;
               end else begin
                  state_d = c_gap;
                  gap_d   = c_gap_len;
               end
            end else if (timer_q == c_timeout_m1) begin
               state_d = c_error;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         c_gap: begin
            if (abort) begin
               state_d = c_idle;
            end else begin
               gap_d = gap_q - 8'd1;
               if (gap_q <= 8'd1) begin
                  state_d = c_arm;
               end
            end
         end
         c_error: begin
            if (abort) begin
               state_d = c_idle;
            end else if (start) begin
               state_d = c_arm;
               cnt_d   = 8'd0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = c_idle;
         end
      endcase
   end

   always_comb begin
      run_d  = (state_d == c_fire);
      busy_d = (state_d == c_arm) || (state_d == c_fire) || (state_d == c_gap);
   end

   assign run       = run_q;
   assign busy      = busy_q;
   assign burst_cnt = cnt_q;
   assign fin       = fin_q;
   assign err       = err_q;

endmodule

`default_nettype wire
